// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver for 8N1/8E1/8O1 frames with a one-entry
// valid/ready holding register and single-cycle parity/framing/overrun reporting.
`timescale 1ns/1ps
module uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       oversample_tick,
  input  logic       rx,
  input  logic       parity_en,
  input  logic       parity_odd,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_perr,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       busy
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t               state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_p;
  logic                 rxs;
  logic [3:0]           os_cnt, os_cnt_nxt;
  logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 perr, perr_nxt;
  logic                 stop_ok;
  logic                 stop_bad;
  logic                 hold_free;

  // Received parity bit against the parity the data bits call for.
  function automatic logic parity_err(input logic bit_rx, input logic odd,
                                      input logic [DATA_BITS-1:0] d);
    return bit_rx ^ (odd ? ~^d : ^d);
  endfunction

  // Synchronizer stage: idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p <= '1;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], rx};
    end
  end

  assign rxs = sync_p[SYNC_STAGES-1];

  // Frame FSM state stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      os_cnt  <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      perr    <= 1'b0;
    end else begin
      state   <= state_nxt;
      os_cnt  <= os_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
      perr    <= perr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    os_cnt_nxt  = os_cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    perr_nxt    = perr;
    stop_ok     = 1'b0;
    stop_bad    = 1'b0;
    if (oversample_tick) begin
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state_nxt  = S_START;
            os_cnt_nxt = '0;
          end
        end
        S_START: begin
          if (os_cnt == 4'd7) begin
            if (rxs) begin
              state_nxt = S_IDLE;
            end else begin
              os_cnt_nxt  = '0;
              bit_idx_nxt = '0;
              perr_nxt    = 1'b0;
              state_nxt   = S_DATA;
            end
          end else begin
            os_cnt_nxt = os_cnt + 4'd1;
          end
        end
        S_DATA: begin
          if (os_cnt == 4'd15) begin
            shreg_nxt   = {rxs, shreg[DATA_BITS-1:1]};
            bit_idx_nxt = bit_idx + IDX_W'(1);
            os_cnt_nxt  = '0;
            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
              state_nxt = parity_en ? S_PAR : S_STOP;
            end
          end else begin
            os_cnt_nxt = os_cnt + 4'd1;
          end
        end
        S_PAR: begin
          if (os_cnt == 4'd15) begin
            perr_nxt   = parity_err(rxs, parity_odd, shreg);
            os_cnt_nxt = '0;
            state_nxt  = S_STOP;
          end else begin
            os_cnt_nxt = os_cnt + 4'd1;
          end
        end
        S_STOP: begin
          // Leaving at mid-stop gives half a bit of slack for the next start edge.
          if (os_cnt == 4'd15) begin
            os_cnt_nxt = '0;
            state_nxt  = S_IDLE;
            stop_ok    = rxs;
            stop_bad   = !rxs;
          end else begin
            os_cnt_nxt = os_cnt + 4'd1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign hold_free = !out_valid || out_ready;

  // Holding register and error pulse stage; a consume and a load may share a cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_perr    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= stop_bad;
      overrun_err <= stop_ok && !hold_free;
      if (stop_ok && hold_free) begin
        out_valid <= 1'b1;
        out_data  <= 8'(shreg);
        out_perr  <= perr;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver: the receive-side counterpart of the team's uart_tx. It recovers 8N1 / 8E1 / 8O1 frames from the asynchronous serial line using the shared 16x oversample_tick. Each received byte is presented on a valid/ready output port with a one-entry holding register. Parity, framing and overrun errors are reported as single-cycle pulses.

Parameters:
DATA_BITS, 8, number of data bits per frame, sent LSB first; out_data width is fixed at 8.
SYNC_STAGES, 2, number of flip-flops in the rx metastability synchronizer; minimum 2.

Ports:
clk  input  1  system clock.
reset_n  input  1  asynchronous, active-low reset.
oversample_tick  input  1  one-clk-wide strobe at 16x the baud rate.
rx  input  1  asynchronous serial input; idles high.
parity_en  input  1  1 = a parity bit follows the data bits.
parity_odd  input  1  1 = odd parity, 0 = even parity; ignored when parity_en=0.
out_valid  output  1  out_data holds an unconsumed byte.
out_ready  input  1  consumer accepts the byte when out_valid && out_ready.
out_data  output  8  received byte.
out_perr  output  1  parity-error flag travelling with out_data; valid while out_valid=1.
frame_err  output  1  one-cycle pulse: stop bit sampled low; the byte is discarded.
overrun_err  output  1  one-cycle pulse: new byte arrived while the holding register was full; the new byte is dropped.
busy  output  1  high whenever the FSM is not in S_IDLE.

Behaviour:
- Reset (reset_n low, asynchronous): state=S_IDLE, all synchronizer flops=1, out_valid=0, out_data=0, out_perr=0, frame_err=0, overrun_err=0, busy=0, counters=0.
- rx passes through SYNC_STAGES flops; the FSM uses only the synchronized value rxs.
- The FSM advances only on cycles where oversample_tick=1. The output handshake and error pulses are evaluated every clk.
- S_IDLE: on a tick with rxs=0, go to S_START with os_cnt=0.
- S_START: os_cnt increments each tick. At os_cnt==7 (mid start bit):
  - rxs=1: false start (glitch), return to S_IDLE.
  - otherwise: os_cnt=0, bit_idx=0, go to S_DATA.
- S_DATA: os_cnt increments each tick. At os_cnt==15 (bit centre):
  - shreg <= {rxs, shreg[7:1]}, bit_idx++, os_cnt=0.
  - After DATA_BITS samples, go to S_PAR if parity_en, else S_STOP.
- S_PAR: at os_cnt==15, perr = rxs XOR (parity_odd ? ~^shreg : ^shreg). Go to S_STOP.
- S_STOP: at os_cnt==15, sample rxs, then go to S_IDLE. Returning at mid-stop permits back-to-back frames.
  - rxs=0: frame_err pulses for 1 clk; the byte is discarded; out_* are unchanged.
  - rxs=1, holding register free: out_data<=shreg, out_perr<=perr, out_valid<=1.
  - "Free" means out_valid=0, or out_ready=1 in the same cycle (simultaneous consume and load is legal: out_valid stays 1, new data loads, no overrun).
  - rxs=1, out_valid=1 and out_ready=0: overrun_err pulses for 1 clk; held data is kept; the new byte is lost.
- Handshake: out_valid clears on the clk edge after out_valid && out_ready, unless a load occurs in that same cycle. out_data and out_perr are stable while out_valid=1 and out_ready=0.
- parity_en and parity_odd are sampled live; they must be held stable during a frame, so a change mid-frame gives undefined parity.
- Latency: out_valid rises 1 clk after the stop-bit centre sample.
- Reset mid-frame aborts immediately; a pending out_valid is lost.

Test Plan:
- oversample_tick tied 1, parity_en=0, out_ready=1; send 0xA5 at 16 clk/bit -> out_valid pulses once with out_data=0xA5, out_perr=0, no error pulses.
- parity_en=1, parity_odd=0; send 0x03 with parity bit 0, then 0x03 with parity bit 1 -> first byte out_perr=0, second out_perr=1. Repeat with parity_odd=1, 0x03 and parity bit 1 -> out_perr=0.
- rx low for 4 ticks then high (glitch) -> FSM returns to S_IDLE, busy falls, no out_valid. A following valid 0x5A frame is received correctly.
- Send 0x3C with the stop bit driven 0 -> frame_err pulses 1 clk; out_valid stays 0.
- out_ready=0; send 0x11 then 0x22 back-to-back -> out_data=0x11 held, overrun_err pulses at the 0x22 stop sample. Raise out_ready -> 0x11 consumed, out_valid=0. Repeat with out_ready=1 on the 0x22 load cycle -> no overrun, out_data=0x22.
- Assert reset_n=0 mid-data bit 4 -> all outputs are at reset values asynchronously. After release, a 0xFF frame is received correctly.
